// File: rtl/signed_div_ctrl.sv
// signed_div_ctrl: multi-cycle signed restoring divider controller (one row per clock)
// Ports:
//   clk, rst (async active-low)
//   start, a, b              : request and signed operands, sampled in IDLE
//   busy, done               : state != IDLE, one-cycle completion pulse
//   quo, rem                 : signed quotient (toward zero) and remainder (sign of a)
//   div_by_zero, overflow    : status of the last accepted operation
module signed_div_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] r, q, mb, ax, bx, am, bm;
  logic [WIDTH+1:0] rp, t;
  logic sq, sr, ovc;
  // magnitudes need one extra bit so |MIN| is representable
  assign ax = {a[WIDTH-1], a};
  assign bx = {b[WIDTH-1], b};
  assign am = a[WIDTH-1] ? -ax : ax;
  assign bm = b[WIDTH-1] ? -bx : bx;
  // one restoring row: shift in next dividend bit, trial-subtract the divisor
  assign rp = {r, q[WIDTH]};
  assign t = rp - {1'b0, mb};
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      r <= '0;
      q <= '0;
      mb <= '0;
      sq <= 1'b0;
      sr <= 1'b0;
      ovc <= 1'b0;
      quo <= '0;
      rem <= '0;
      div_by_zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          div_by_zero <= b == '0;
          overflow <= 1'b0;
          cnt <= '0;
          if (b == '0) begin
            quo <= '0;
            rem <= a;
            state <= DONE;
          end else begin
            q <= am;
            r <= '0;
            mb <= bm;
            sq <= a[WIDTH-1] ^ b[WIDTH-1];
            sr <= a[WIDTH-1];
            ovc <= (a == MIN) && (b == '1);
            state <= DIV;
          end
        end
        DIV: begin
          r <= t[WIDTH+1] ? rp[WIDTH:0] : t[WIDTH:0];
          q <= {q[WIDTH-1:0], ~t[WIDTH+1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH)) state <= FIX;
        end
        FIX: begin
          quo <= sq ? -q[WIDTH-1:0] : q[WIDTH-1:0];
          rem <= sr ? -r[WIDTH-1:0] : r[WIDTH-1:0];
          overflow <= ovc;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_signed_div_ctrl.sv
// tb_signed_div_ctrl: randomized and directed checks of signed_div_ctrl against an integer-division model
module tb_signed_div_ctrl;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, div_by_zero, overflow;
  logic [W-1:0] quo, rem;
  int n_cmp = 0, n_err = 0;

  signed_div_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quo(quo), .rem(rem),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] eq, output logic [W-1:0] er,
                                output logic ez, output logic eo);
    int xi, yi, qi, ri;
    xi = int'($signed(x));
    yi = int'($signed(y));
    if (yi == 0) begin
      eq = '0; er = x; ez = 1'b1; eo = 1'b0;
    end else begin
      qi = xi / yi;
      ri = xi % yi;
      eq = qi[W-1:0];
      er = ri[W-1:0];
      ez = 1'b0;
      eo = (xi == -(1 << (W-1))) && (yi == -1);
    end
  endfunction

  task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb_, input bit junk);
    logic [W-1:0] eq, er;
    logic ez, eo;
    int lat, k;
    model(ta, tb_, eq, er, ez, eo);
    lat = (tb_ == '0) ? 0 : W + 2;
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1;
    if (junk) begin a = W'($urandom); b = W'($urandom); end else start = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      chk("busy_during", 32'(busy), 32'd1);
      @(posedge clk); #1;
      k++;
      if (junk) begin a = W'($urandom); b = W'($urandom); end
    end
    start = 1'b0;
    chk("latency", 32'(k), 32'(lat));
    chk("busy_at_done", 32'(busy), 32'd1);
    chk("quo", 32'(quo), 32'(eq));
    chk("rem", 32'(rem), 32'(er));
    chk("div_by_zero", 32'(div_by_zero), 32'(ez));
    chk("overflow", 32'(overflow), 32'(eo));
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("quo_hold", 32'(quo), 32'(eq));
    chk("rem_hold", 32'(rem), 32'(er));
  endtask

  initial begin
    #1 rst = 1'b0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quo", 32'(quo), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run(4'd7, 4'd2, 1'b0);
    run(4'b1001, 4'd2, 1'b0);
    run(4'd7, 4'b1101, 1'b0);
    run(4'b1000, 4'b1111, 1'b0);
    run(4'b1000, 4'd2, 1'b0);
    run(4'd5, 4'd0, 1'b0);
    run(4'd0, 4'd3, 1'b0);
    run(4'd2, 4'd5, 1'b0);
    run(4'b1111, 4'b1000, 1'b0);
    run(4'b1000, 4'b1000, 1'b0);
    run(4'd7, 4'd2, 1'b1);
    run(4'd6, 4'd3, 1'b0);
    @(negedge clk);
    a = 4'd7; b = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quo", 32'(quo), 32'd0);
    chk("abort_rem", 32'(rem), 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    run(4'd7, 4'd2, 1'b0);
    for (int i = 0; i < 60; i++) run(W'($urandom), W'($urandom_range(0, 3) == 0 ? 0 : $urandom), 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
